life_step_engine: RTL and testbench

//  Computes successive Game of Life generations on a 64x48 interior board held
//  in a 66x50 dead-bordered frame. The frame is bit-packed as y*66+x.

---
 rtl/life_step_engine.sv | 160 ++++++++++++++++
 tb/tb_life_step_engine.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_step_engine.sv
`default_nettype none
// ============================================================================
//  Module      : life_step_engine
//  Description : Game of Life (B3/S23) generation engine on a COLS x ROWS
//                interior board held in a dead-bordered (COLS+2)x(ROWS+2)
//                frame, bit-packed as y*FW+x. One interior row is computed per
//                clock into a shadow buffer; the finished generation is
//                committed to the visible board in a single edge, so a
//                downstream display never sees a torn generation.
//  Ports       : clk        - system clock, rising edge
//                rst_n      - asynchronous active-low reset
//                seed_load  - 1-cycle pulse, load seed_data as current board
//                seed_data  - seed frame (border bits ignored)
//                step       - 1-cycle pulse, compute one generation
//                busy       - high while a generation is being computed
//                done       - 1-cycle pulse when a new board is committed
//                generation - generations since last seed/reset (wraps)
//                board      - current frame, border bits always 0
//  Revision    : 1.0 - initial release
// ============================================================================
module life_step_engine #(
    parameter int COLS  = 64,
    parameter int ROWS  = 48,
    parameter int GEN_W = 16,
    localparam int FW   = COLS + 2,
    localparam int FH   = ROWS + 2,
    localparam int NB   = FW * FH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [NB-1:0]    seed_data,
    input  logic             step,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] generation,
    output logic [NB-1:0]    board
);

    localparam int ROW_W = $clog2(FH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_COMMIT  = 2'd2;

    logic [1:0]       r_state_q, w_state_d;
    logic [ROW_W-1:0] r_row_q,   w_row_d;
    logic             r_busy_q,  w_busy_d;
    logic             r_done_q,  w_done_d;
    logic [GEN_W-1:0] r_gen_q,   w_gen_d;
    logic [NB-1:0]    r_board_q, w_board_d;
    logic [NB-1:0]    r_shadow_q, w_shadow_d;

    // Constant mask of interior cells; everything else is the dead border.
    logic [NB-1:0] w_interior;

    for (genvar gi = 0; gi < NB; gi++) begin : g_mask
        localparam int GY = gi / FW;
        localparam int GX = gi % FW;
        assign w_interior[gi] = (GX >= 1) && (GX <= COLS) && (GY >= 1) && (GY <= ROWS);
    end

    // Row being computed and its two neighbours. The row index is clamped to
    // the interior so the slices stay in range outside COMPUTE.
    logic [ROW_W-1:0] w_row_eff;
    int               w_base;
    logic [FW-1:0]    w_above, w_mid, w_below, w_new_row;
    logic [3:0]       w_cnt;

    always_comb begin
        w_row_eff = r_row_q;
        if (r_row_q == '0)
            w_row_eff = ROW_W'(1);
        else if (r_row_q > ROW_W'(ROWS))
            w_row_eff = ROW_W'(ROWS);
        w_base  = int'(w_row_eff) * FW;
        w_above = r_board_q[w_base - FW +: FW];
        w_mid   = r_board_q[w_base +: FW];
        w_below = r_board_q[w_base + FW +: FW];

        w_new_row = '0;
        w_cnt     = '0;
        for (int x = 1; x <= COLS; x++) begin
            w_cnt = 4'(w_above[x-1]) + 4'(w_above[x]) + 4'(w_above[x+1])
                  + 4'(w_mid[x-1])                    + 4'(w_mid[x+1])
                  + 4'(w_below[x-1]) + 4'(w_below[x]) + 4'(w_below[x+1]);
            w_new_row[x] = (w_cnt == 4'd3) || (w_mid[x] && (w_cnt == 4'd2));
        end
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_row_d    = r_row_q;
        w_busy_d   = r_busy_q;
        w_done_d   = 1'b0;
        w_gen_d    = r_gen_q;
        w_board_d  = r_board_q;
        w_shadow_d = r_shadow_q;

        case (r_state_q)
            S_IDLE: begin
                // A seed wins over a coincident step; the step is dropped.
                if (seed_load) begin
                    w_board_d = seed_data & w_interior;
                    w_gen_d   = '0;
                end else if (step) begin
                    w_row_d   = ROW_W'(1);
                    w_busy_d  = 1'b1;
                    w_state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                w_shadow_d[w_base +: FW] = w_new_row;
                w_row_d = r_row_q + ROW_W'(1);
                if (r_row_q == ROW_W'(ROWS))
                    w_state_d = S_COMMIT;
            end
            S_COMMIT: begin
                w_board_d = r_shadow_q & w_interior;
                w_gen_d   = r_gen_q + GEN_W'(1);
                w_done_d  = 1'b1;
                w_busy_d  = 1'b0;
                w_row_d   = '0;
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
                w_busy_d  = 1'b0;
                w_row_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q  <= S_IDLE;
            r_row_q    <= '0;
            r_busy_q   <= 1'b0;
            r_done_q   <= 1'b0;
            r_gen_q    <= '0;
            r_board_q  <= '0;
            r_shadow_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_row_q    <= w_row_d;
            r_busy_q   <= w_busy_d;
            r_done_q   <= w_done_d;
            r_gen_q    <= w_gen_d;
            r_board_q  <= w_board_d;
            r_shadow_q <= w_shadow_d;
        end
    end

    assign busy       = r_busy_q;
    assign done       = r_done_q;
    assign generation = r_gen_q;
    assign board      = r_board_q;

endmodule
`default_nettype wire

// File: tb/tb_life_step_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_life_step_engine
//  Description : Self-checking bench for life_step_engine. A transaction-level
//                model tracks the expected board, generation, busy and done;
//                a compare process checks two DUT instances (16-bit and 3-bit
//                generation counters, shared inputs) against it every cycle.
//                Directed hand-computed expectations pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_life_step_engine;

    localparam int COLS = 64;
    localparam int ROWS = 48;
    localparam int FW   = COLS + 2;
    localparam int NB   = FW * (ROWS + 2);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          seed_load = 1'b0;
    logic [NB-1:0] seed_data = '0;
    logic          step = 1'b0;

    logic          busy, done;
    logic [15:0]   generation;
    logic [NB-1:0] board;
    logic          busy_s, done_s;
    logic [2:0]    gen_s;
    logic [NB-1:0] board_s;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    always #5 clk = ~clk;

    life_step_engine #(.COLS(COLS), .ROWS(ROWS), .GEN_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_data(seed_data),
        .step(step), .busy(busy), .done(done), .generation(generation), .board(board)
    );

    life_step_engine #(.COLS(COLS), .ROWS(ROWS), .GEN_W(3)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_data(seed_data),
        .step(step), .busy(busy_s), .done(done_s), .generation(gen_s), .board(board_s)
    );

    // ---------------------------------------------------------------- helpers
    function automatic logic [NB-1:0] mk(input int a, input int b, input int c, input int d);
        logic [NB-1:0] v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        if (d >= 0) v[d] = 1'b1;
        return v;
    endfunction

    function automatic logic [NB-1:0] interior_mask();
        logic [NB-1:0] v = '0;
        for (int y = 1; y <= ROWS; y++)
            for (int x = 1; x <= COLS; x++)
                v[y*FW+x] = 1'b1;
        return v;
    endfunction

    // Plain B3/S23 over the frame; anything outside the interior is dead.
    function automatic logic [NB-1:0] life_next(input logic [NB-1:0] b);
        logic [NB-1:0] r = '0;
        int n;
        for (int y = 1; y <= ROWS; y++) begin
            for (int x = 1; x <= COLS; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dy != 0 || dx != 0)
                            n += int'(b[(y+dy)*FW + x + dx]);
                r[y*FW+x] = (n == 3) || (b[y*FW+x] && n == 2);
            end
        end
        return r;
    endfunction

    function automatic int first_diff(input logic [NB-1:0] a, input logic [NB-1:0] b);
        for (int i = 0; i < NB; i++)
            if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    int fail_prints = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
            end
        end
    endtask

    task automatic chk_board(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s: got popcount %0d expected popcount %0d, first differing bit %0d (t=%0t)",
                         name, $countones(act), $countones(exp), first_diff(act, exp), $time);
            end
        end
    endtask

    // ------------------------------------------------------------------ model
    logic [NB-1:0] m_board = '0;
    int            m_gen   = 0;
    bit            m_busy  = 1'b0;
    bit            m_done  = 1'b0;
    int            m_cnt   = 0;
    logic [NB-1:0] c_mask;

    initial c_mask = interior_mask();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_board = '0; m_gen = 0; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
        end else if (m_busy) begin
            // Accepted step at edge N commits at edge N+49.
            m_cnt++;
            if (m_cnt == 49) begin
                m_board = life_next(m_board);
                m_gen   = m_gen + 1;
                m_done  = 1'b1;
                m_busy  = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (seed_load) begin
                m_board = seed_data & c_mask;
                m_gen   = 0;
            end else if (step) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk_board("model_board", board, m_board);
            chk("model_gen", longint'(generation), longint'(m_gen % 65536));
            chk("model_busy", longint'(busy), longint'(m_busy));
            chk("model_done", longint'(done), longint'(m_done));
            chk("busy_and_done", longint'(busy && done), 0);
            chk_board("model_board_w", board_s, m_board);
            chk("model_gen_w", longint'(gen_s), longint'(m_gen % 8));
            chk("model_busy_w", longint'(busy_s), longint'(m_busy));
            chk("model_done_w", longint'(done_s), longint'(m_done));
        end
    end

    // --------------------------------------------------------------- drivers
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_seed(input logic [NB-1:0] v);
        @(negedge clk);
        seed_load = 1'b1;
        seed_data = v;
        @(negedge clk);
        seed_load = 1'b0;
    endtask

    task automatic do_step();
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    // Counts negedges after the step pulse until done is seen; bounded.
    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 70) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    // ---------------------------------------------------------------- stimulus
    int k;
    int dones;
    int g0;

    initial begin
        // Reset state
        #3;
        chk_board("reset_board", board, '0);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done), 0);
        chk("reset_gen", longint'(generation), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick(2);

        // 1: blinker oscillates
        do_seed(mk(670, 671, 672, -1));
        chk_board("blinker_seed", board, mk(670, 671, 672, -1));
        do_step();
        wait_done(k);
        chk_board("blinker_gen1", board, mk(605, 671, 737, -1));
        chk("blinker_gen1_count", longint'(generation), 1);
        tick(1);
        do_step();
        wait_done(k);
        chk_board("blinker_gen2", board, mk(670, 671, 672, -1));
        chk("blinker_gen2_count", longint'(generation), 2);
        tick(1);

        // 2: corner block is still life; done 49 cycles after the step edge
        do_seed(mk(67, 68, 133, 134));
        chk("block_seed_gen", longint'(generation), 0);
        do_step();
        wait_done(k);
        chk("block_done_latency", k, 49);
        chk_board("block_stable", board, mk(67, 68, 133, 134));
        chk("block_gen", longint'(generation), 1);
        tick(1);
        chk("block_done_width", longint'(done), 0);

        // 3: border bits of the seed are dropped
        do_seed(mk(0, 65, 3299, 671));
        chk_board("border_forced", board, mk(671, -1, -1, -1));
        do_step();
        wait_done(k);
        chk_board("lone_cell_dies", board, '0);
        tick(1);

        // 4: a second step while busy is ignored
        do_seed(mk(670, 671, 672, -1));
        g0 = int'(generation);
        do_step();
        tick(8);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        dones = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("busy_step_dones", dones, 1);
        chk("busy_step_gen", longint'(generation), longint'(g0 + 1));

        // 5: asynchronous reset in the middle of a computation
        do_step();
        tick(19);
        #2 rst_n = 1'b0;
        #1;
        chk_board("midreset_board", board, '0);
        chk("midreset_busy", longint'(busy), 0);
        chk("midreset_gen", longint'(generation), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        do_seed(mk(670, 671, 672, -1));
        do_step();
        wait_done(k);
        chk("post_reset_latency", k, 49);
        chk_board("post_reset_blinker", board, mk(605, 671, 737, -1));
        chk("post_reset_gen", longint'(generation), 1);
        tick(1);

        // 6: generation wraps (3-bit instance after 8 steps on empty board)
        do_seed('0);
        for (int i = 0; i < 8; i++) begin
            do_step();
            wait_done(k);
            tick(1);
        end
        chk("wrap_gen_w", longint'(gen_s), 0);
        chk("wrap_gen", longint'(generation), 8);
        // seed_load and step in the same cycle: seed only
        @(negedge clk);
        seed_load = 1'b1;
        step      = 1'b1;
        seed_data = mk(67, 68, 133, -1);
        @(negedge clk);
        seed_load = 1'b0;
        step      = 1'b0;
        chk("seed_prio_busy", longint'(busy), 0);
        chk("seed_prio_gen", longint'(generation), 0);
        chk_board("seed_prio_board", board, mk(67, 68, 133, -1));
        tick(5);
        chk("seed_prio_still_idle", longint'(busy), 0);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1);
    end

endmodule
`default_nettype wire
